// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Imported by lsu_align and lsu_ctrl.
package lsu_pkg;

   localparam int DMEM_WIDTH = 32;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT_R,
      S_DONE
   } lsu_state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering, byte enables, load extension
// and legality check for a single data access.
module lsu_align
   import lsu_pkg::*;
(
   input  logic                  mem_read,
   input  logic                  mem_write,
   input  logic [2:0]            func3,
   input  logic [1:0]            addr_lo,
   input  logic [DMEM_WIDTH-1:0] store_data,
   input  logic [2:0]            ld_func3,
   input  logic [1:0]            ld_lo,
   input  logic [DMEM_WIDTH-1:0] rdata,
   output logic [DMEM_WIDTH-1:0] wdata,
   output logic [3:0]            be,
   output logic [DMEM_WIDTH-1:0] ld_ext,
   output logic                  illegal
);

   logic [DMEM_WIDTH-1:0] shifted;
   logic                  bad_f3;
   logic                  misal;

   always_comb begin
      wdata  = store_data;
      be     = 4'b1111;
      bad_f3 = 1'b1;
      misal  = 1'b0;
      case (func3)
         F3_B, F3_BU: begin
            wdata  = {4{store_data[7:0]}};
            be     = 4'b0001 << addr_lo;
            bad_f3 = (func3 == F3_BU) && mem_write;
         end
         F3_H, F3_HU: begin
            wdata  = {2{store_data[15:0]}};
            be     = 4'b0011 << addr_lo;
            bad_f3 = (func3 == F3_HU) && mem_write;
            misal  = addr_lo[0];
         end
         F3_W: begin
            bad_f3 = 1'b0;
            misal  = |addr_lo;
         end
         default: ;
      endcase
      illegal = (mem_read & mem_write) | bad_f3 | misal;
   end

   // Extraction uses the lane/width latched at accept time.
   always_comb begin
      shifted = rdata >> {ld_lo, 3'b000};
      case (ld_func3)
         F3_B:    ld_ext = {{24{shifted[7]}}, shifted[7:0]};
         F3_BU:   ld_ext = {24'h0, shifted[7:0]};
         F3_H:    ld_ext = {{16{shifted[15]}}, shifted[15:0]};
         F3_HU:   ld_ext = {16'h0, shifted[15:0]};
         default: ld_ext = rdata;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: request/grant/response handshake to
// data memory with core stall, timeout and access error flags.
module lsu_ctrl
   import lsu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mem_read,
   input  logic                  mem_write,
   input  logic [2:0]            func3,
   input  logic [DMEM_WIDTH-1:0] addr,
   input  logic [DMEM_WIDTH-1:0] store_data,
   output logic                  stall,
   output logic [DMEM_WIDTH-1:0] load_data,
   output logic                  load_valid,
   output logic                  access_err,
   output logic                  dmem_req,
   output logic                  dmem_we,
   output logic [DMEM_WIDTH-1:0] dmem_addr,
   output logic [DMEM_WIDTH-1:0] dmem_wdata,
   output logic [3:0]            dmem_be,
   input  logic                  dmem_gnt,
   input  logic                  dmem_rvalid,
   input  logic [DMEM_WIDTH-1:0] dmem_rdata
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   lsu_state_t            state_q, state_d;
   logic [CW-1:0]         cnt_q;
   logic [1:0]            lo_q;
   logic [2:0]            f3_q;
   logic                  rd_q;
   logic                  err_q;
   logic                  accept;
   logic                  capture;
   logic                  tmo;
   logic                  last;
   logic                  illegal;
   logic [DMEM_WIDTH-1:0] wdata;
   logic [3:0]            be;
   logic [DMEM_WIDTH-1:0] ld_ext;

   lsu_align u_align (
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .func3      (func3),
      .addr_lo    (addr[1:0]),
      .store_data (store_data),
      .ld_func3   (f3_q),
      .ld_lo      (lo_q),
      .rdata      (dmem_rdata),
      .wdata      (wdata),
      .be         (be),
      .ld_ext     (ld_ext),
      .illegal    (illegal)
   );

   assign last     = (cnt_q == CNT_LAST);
   assign dmem_req = (state_q == S_REQ);

   always_comb begin
      state_d    = state_q;
      accept     = 1'b0;
      capture    = 1'b0;
      tmo        = 1'b0;
      stall      = 1'b0;
      access_err = 1'b0;
      load_valid = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            // Gated by rst so a held access cannot stall during reset.
            if ((mem_read | mem_write) && !rst) begin
               if (illegal) begin
                  access_err = 1'b1;
               end else begin
                  accept  = 1'b1;
                  stall   = 1'b1;
                  state_d = S_REQ;
               end
            end
         end
         S_REQ: begin
            stall = 1'b1;
            if (dmem_gnt) state_d = dmem_we ? S_DONE : S_WAIT_R;
            if (last && !(dmem_gnt && dmem_we)) begin
               state_d = S_DONE;
               tmo     = 1'b1;
            end
         end
         S_WAIT_R: begin
            stall = 1'b1;
            if (dmem_rvalid) begin
               capture = 1'b1;
               state_d = S_DONE;
            end else if (last) begin
               tmo     = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            access_err = err_q;
            load_valid = rd_q & ~err_q;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         lo_q       <= 2'b00;
         f3_q       <= 3'b000;
         rd_q       <= 1'b0;
         err_q      <= 1'b0;
         load_data  <= '0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         dmem_be    <= 4'b0000;
      end else begin
         state_q <= state_d;
         if (accept) begin
            cnt_q      <= '0;
            err_q      <= 1'b0;
            lo_q       <= addr[1:0];
            f3_q       <= func3;
            rd_q       <= mem_read;
            dmem_we    <= mem_write;
            dmem_addr  <= {addr[31:2], 2'b00};
            dmem_wdata <= wdata;
            dmem_be    <= be;
         end else if (stall) begin
            cnt_q <= cnt_q + CW'(1);
         end
         if (tmo) begin
            err_q     <= 1'b1;
            load_data <= '0;
         end
         if (capture) load_data <= ld_ext;
      end
   end

endmodule
